// File: rtl/mlp_pkg.sv
// Shared types and fixed-point helpers for the MLP layer-2 datapath.
// sat_q88 rounds a wide accumulator to nearest and clips it into Q8.8.
package mlp_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;

  typedef logic signed [DATA_W-1:0] q88_t;

  typedef enum logic [2:0] {IDLE, MAC, ROUND, OUT, FIN} l2_state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // One guard bit above ACC_W keeps the rounding bias from wrapping at full scale.
  function automatic q88_t sat_q88(input logic signed [ACC_W-1:0] acc,
                                   input int frac_w = FRAC_W);
    logic signed [ACC_W:0] r;
    r = (ACC_W+1)'(acc) + ((ACC_W+1)'(1) << (frac_w-1));
    r = r >>> frac_w;
    if (r > SAT_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
    if (r < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mlp_round_sat.sv
// Combinational accumulator -> Q8.8 conversion (round, saturate).
// Build option LAYER2_RELU_EN additionally clamps negative results to zero.
module mlp_round_sat
  import mlp_pkg::*;
#(
  parameter int FRAC_BITS = mlp_pkg::FRAC_W
) (
  input  logic signed [ACC_W-1:0] acc,
  output q88_t                    res
);

  q88_t r;

  assign r = sat_q88(acc, FRAC_BITS);

`ifdef LAYER2_RELU_EN
  assign res = r[DATA_W-1] ? '0 : r;
`else
  assign res = r;
`endif

endmodule

// File: rtl/layer2_mac_seq.sv
// Layer-2 MAC sequencer: walks weights/activations, accumulates one output neuron at a time,
// rounds to Q8.8 and offers each result over valid/ready. LAYER2_RELU_EN selects ReLU output.
module layer2_mac_seq #(
  parameter int N_IN   = 128,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        weight_addr,
  input  logic [DATA_W-1:0]        weight_data,
  output logic [$clog2(N_IN)-1:0]  act_addr,
  input  logic [DATA_W-1:0]        act_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_OUT)-1:0] out_idx,
  output logic [DATA_W-1:0]        out_data
);
  import mlp_pkg::*;

  localparam int I_W = $clog2(N_IN);
  localparam int N_W = $clog2(N_OUT);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN-1);
  localparam logic [N_W-1:0] N_LAST = N_W'(N_OUT-1);

  l2_state_t               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [I_W-1:0]          i_q, i_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [ADDR_W-1:0]       wa_q, wa_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ov_q, ov_d;
  logic [N_W-1:0]          oidx_q, oidx_d;
  logic [DATA_W-1:0]       odata_q, odata_d;

  logic signed [2*DATA_W-1:0] prod;
  q88_t                       rnd;

  assign prod = $signed(weight_data) * $signed(act_data);

  mlp_round_sat #(.FRAC_BITS(FRAC_W)) u_round_sat (
    .acc (acc_q),
    .res (rnd)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    n_d     = n_q;
    wa_d    = wa_q;
    done_d  = 1'b0;
    ov_d    = ov_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    unique case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        i_d     = '0;
        n_d     = '0;
        wa_d    = '0;
        state_d = MAC;
      end
      // weight_addr runs on across neurons, so it lands on the next neuron's base for free
      MAC: begin
        acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        wa_d  = wa_q + 1'b1;
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = ROUND;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ROUND: begin
        odata_d = rnd;
        oidx_d  = n_q;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        ov_d  = 1'b0;
        acc_d = '0;
        if (n_q == N_LAST) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = MAC;
        end
      end
      FIN: begin
        wa_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      wa_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      n_q     <= n_d;
      wa_q    <= wa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign weight_addr = wa_q;
  assign act_addr    = i_q;
  assign out_valid   = ov_q;
  assign out_idx     = oidx_q;
  assign out_data    = odata_q;

endmodule

// File: tb/tb_layer2_mac_seq.sv
// Directed bench for layer2_mac_seq with N_IN=4, N_OUT=3 and modelled weight/activation memories.
module tb_layer2_mac_seq;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic        busy, done, out_valid;
  logic [13:0] weight_addr;
  logic [15:0] weight_data, act_data, out_data;
  logic [1:0]  act_addr, out_idx;

  logic [15:0] wmem [0:11];
  logic [15:0] amem [0:3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] res_data [$];
  logic [1:0]  res_idx  [$];
  int          res_cyc  [$];
  int          n_done;
  int          done_cyc;

  layer2_mac_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .ADDR_W(14)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .act_addr(act_addr), .act_data(act_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    weight_data = 16'h0000;
    if (weight_addr < 14'd12) weight_data = wmem[weight_addr[3:0]];
    act_data = amem[act_addr];
  end

  // Records handshakes and done pulses; inputs only change on negedge +0.
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      res_data.push_back(out_data);
      res_idx.push_back(out_idx);
      res_cyc.push_back(cyc);
    end
    if (done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic clr_log();
    res_data.delete();
    res_idx.delete();
    res_cyc.delete();
    n_done   = 0;
    done_cyc = -1;
  endtask

  task automatic pulse_start(output int c);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_pass(output int c, output bit ok);
    clr_log();
    out_ready = 1'b1;
    pulse_start(c);
    ok = 1'b0;
    repeat (200) begin
      @(negedge clk);
      #3;
      if (n_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_basic(input bit per_neuron);
    for (int k = 0; k < 12; k++) wmem[k] = per_neuron ? 16'((k/4 + 1) << 8) : 16'h0100;
    amem[0] = 16'h0100; amem[1] = 16'h0200; amem[2] = 16'h0300; amem[3] = 16'hFF00;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, out_valid} !== 3'b000) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {busy, done, out_valid}); end
    checks++; if (weight_addr !== 14'd0) begin failures++;
      $display("FAIL reset_waddr got=%0d exp=0", weight_addr); end
    checks++; if (act_addr !== 2'd0) begin failures++;
      $display("FAIL reset_aaddr got=%0d exp=0", act_addr); end
    checks++; if ({out_idx, out_data} !== 18'd0) begin failures++;
      $display("FAIL reset_out got=%h/%h exp=0/0", out_idx, out_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int c;
    load_basic(1'b0);
    clr_log();
    out_ready = 1'b1;
    pulse_start(c);
    // Per neuron: 4 MAC cycles, ROUND, OUT; FIN follows the last accept.
    for (int k = 1; k <= 19; k++) begin
      int n, p;
      wait_cyc(c + k);
      n = (k - 1) / 6;
      p = (k - 1) % 6;
      checks++; if (busy !== 1'b1) begin failures++;
        $display("FAIL basic_busy k=%0d got=%b exp=1", k, busy); end
      if (k <= 18) begin
        checks++; if (out_valid !== (p == 5)) begin failures++;
          $display("FAIL basic_valid k=%0d got=%b exp=%b", k, out_valid, (p == 5)); end
      end
      if (k <= 18 && p < 4) begin
        checks++; if (weight_addr !== 14'(n*4 + p) || act_addr !== 2'(p)) begin failures++;
          $display("FAIL basic_addr k=%0d got=%0d/%0d exp=%0d/%0d", k, weight_addr, act_addr, n*4+p, p); end
      end
    end
    wait_cyc(c + 20);
    checks++; if (busy !== 1'b0 || weight_addr !== 14'd0) begin failures++;
      $display("FAIL basic_end got busy=%b waddr=%0d exp=0/0", busy, weight_addr); end
    checks++; if (res_data.size() !== 3) begin failures++;
      $display("FAIL basic_count got=%0d exp=3", res_data.size()); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== 16'h0500 || res_idx[j] !== 2'(j) || res_cyc[j] !== c + 6 + 6*j) begin
        failures++;
        $display("FAIL basic_res j=%0d got=%h/%0d@%0d exp=0500/%0d@%0d",
                 j, res_data[j], res_idx[j], res_cyc[j] - c, j, 6 + 6*j);
      end
    end
    checks++; if (n_done !== 1 || done_cyc !== c + 19) begin failures++;
      $display("FAIL basic_done got=%0d@%0d exp=1@19", n_done, done_cyc - c); end
  endtask

  task automatic test_back_pressure();
    int c;
    logic [15:0] exp_d [3] = '{16'h0500, 16'h0A00, 16'h0F00};
    int          exp_c [3] = '{6, 17, 23};
    load_basic(1'b1);
    clr_log();
    out_ready = 1'b1;
    pulse_start(c);
    wait_cyc(c + 11);
    out_ready = 1'b0;
    for (int k = 12; k <= 17; k++) begin
      wait_cyc(c + k);
      checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 16'h0A00) begin failures++;
        $display("FAIL bp_hold k=%0d got=%b/%0d/%h exp=1/1/0a00", k, out_valid, out_idx, out_data); end
      checks++; if (weight_addr !== 14'd8 || act_addr !== 2'd0) begin failures++;
        $display("FAIL bp_stall k=%0d got=%0d/%0d exp=8/0", k, weight_addr, act_addr); end
    end
    out_ready = 1'b1;
    wait_cyc(c + 18);
    checks++; if (out_valid !== 1'b0 || weight_addr !== 14'd8 || busy !== 1'b1) begin failures++;
      $display("FAIL bp_resume got=%b/%0d/%b exp=0/8/1", out_valid, weight_addr, busy); end
    wait_cyc(c + 19);
    checks++; if (weight_addr !== 14'd9 || act_addr !== 2'd1) begin failures++;
      $display("FAIL bp_progress got=%0d/%0d exp=9/1", weight_addr, act_addr); end
    wait_cyc(c + 25);
    checks++; if (res_data.size() !== 3) begin failures++;
      $display("FAIL bp_count got=%0d exp=3", res_data.size()); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== exp_d[j] || res_idx[j] !== 2'(j) || res_cyc[j] !== c + exp_c[j]) begin
        failures++;
        $display("FAIL bp_res j=%0d got=%h/%0d@%0d exp=%h/%0d@%0d",
                 j, res_data[j], res_idx[j], res_cyc[j] - c, exp_d[j], j, exp_c[j]);
      end
    end
    checks++; if (n_done !== 1 || done_cyc !== c + 24 || busy !== 1'b0) begin failures++;
      $display("FAIL bp_done got=%0d@%0d busy=%b exp=1@24 busy=0", n_done, done_cyc - c, busy); end
  endtask

  task automatic test_saturation();
    int c;
    bit ok;
    logic [15:0] exp_neg;
`ifdef LAYER2_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8000;
`endif
    for (int k = 0; k < 12; k++) wmem[k] = 16'h7FFF;
    for (int k = 0; k < 4; k++) amem[k] = 16'h7FFF;
    run_pass(c, ok);
    checks++; if (!ok || res_data.size() !== 3) begin failures++;
      $display("FAIL sat_pos_pass got ok=%b n=%0d exp=1/3", ok, res_data.size()); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== 16'h7FFF) begin failures++;
        $display("FAIL sat_pos j=%0d got=%h exp=7fff", j, res_data[j]); end
    end
    for (int k = 0; k < 4; k++) amem[k] = 16'h8001;
    run_pass(c, ok);
    checks++; if (!ok || res_data.size() !== 3) begin failures++;
      $display("FAIL sat_neg_pass got ok=%b n=%0d exp=1/3", ok, res_data.size()); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== exp_neg) begin failures++;
        $display("FAIL sat_neg j=%0d got=%h exp=%h", j, res_data[j], exp_neg); end
    end
  endtask

  task automatic test_rounding();
    int c;
    bit ok;
    logic [15:0] a0   [3] = '{16'h0080, 16'h007F, 16'hFF7F};
    logic [15:0] expd [3];
    expd[0] = 16'h0001;
    expd[1] = 16'h0000;
`ifdef LAYER2_RELU_EN
    expd[2] = 16'h0000;
`else
    expd[2] = 16'hFFFF;
`endif
    for (int k = 0; k < 12; k++) wmem[k] = (k % 4 == 0) ? 16'h0001 : 16'h0000;
    amem[1] = 16'h0000; amem[2] = 16'h0000; amem[3] = 16'h0000;
    for (int v = 0; v < 3; v++) begin
      amem[0] = a0[v];
      run_pass(c, ok);
      checks++; if (!ok || res_data.size() !== 3) begin failures++;
        $display("FAIL rnd_pass v=%0d got ok=%b n=%0d exp=1/3", v, ok, res_data.size()); end
      else for (int j = 0; j < 3; j++) begin
        checks++; if (res_data[j] !== expd[v]) begin failures++;
          $display("FAIL rnd v=%0d j=%0d got=%h exp=%h", v, j, res_data[j], expd[v]); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int c;
    load_basic(1'b0);
    clr_log();
    out_ready = 1'b1;
    pulse_start(c);
    wait_cyc(c + 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 19);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 22);
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL start_fin_restart got busy=%b exp=0", busy); end
    checks++; if (res_data.size() !== 3 || n_done !== 1 || done_cyc !== c + 19) begin failures++;
      $display("FAIL start_ignored got n=%0d done=%0d@%0d exp=3 1@19", res_data.size(), n_done, done_cyc - c); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== 16'h0500 || res_idx[j] !== 2'(j)) begin failures++;
        $display("FAIL start_res j=%0d got=%h/%0d exp=0500/%0d", j, res_data[j], res_idx[j], j); end
    end
  endtask

  task automatic test_reset_mid_pass();
    int c, c2;
    bit ok;
    load_basic(1'b0);
    clr_log();
    out_ready = 1'b1;
    pulse_start(c);
    wait_cyc(c + 14);
    reset = 1'b1;
    #1;
    checks++; if ({busy, done, out_valid} !== 3'b000 || weight_addr !== 14'd0 || act_addr !== 2'd0
                  || out_idx !== 2'd0 || out_data !== 16'h0000) begin failures++;
      $display("FAIL rst_mid_async got=%b %0d %0d %0d %h exp=000 0 0 0 0000",
               {busy, done, out_valid}, weight_addr, act_addr, out_idx, out_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || n_done !== 0 || res_data.size() !== 2) begin
      failures++;
      $display("FAIL rst_mid_abort got busy=%b valid=%b done=%0d n=%0d exp=0 0 0 2",
               busy, out_valid, n_done, res_data.size()); end
    reset = 1'b0;
    @(negedge clk);
    run_pass(c2, ok);
    checks++; if (!ok || res_data.size() !== 3 || n_done !== 1 || done_cyc !== c2 + 19) begin failures++;
      $display("FAIL rst_mid_rerun got ok=%b n=%0d done=%0d@%0d exp=1 3 1@19",
               ok, res_data.size(), n_done, done_cyc - c2); end
    else for (int j = 0; j < 3; j++) begin
      checks++; if (res_data[j] !== 16'h0500 || res_idx[j] !== 2'(j) || res_cyc[j] !== c2 + 6 + 6*j) begin
        failures++;
        $display("FAIL rst_mid_res j=%0d got=%h/%0d@%0d exp=0500/%0d@%0d",
                 j, res_data[j], res_idx[j], res_cyc[j] - c2, j, 6 + 6*j);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) wmem[k] = 16'h0000;
    for (int k = 0; k < 4; k++) amem[k] = 16'h0000;
    clr_log();
    test_reset();
    test_basic();
    test_back_pressure();
    test_saturation();
    test_rounding();
    test_start_ignored();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
